// File: rtl/wb_pipe_stage_pkg.sv
// Shared write-back definitions: source select codes and stage state encoding.
package wb_pipe_stage_pkg;

    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_MEM = 1;
    localparam int WB_SRC_PC  = 2;
    localparam int WB_SRC_IMM = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_VALID    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_src_mux.sv
// Combinational write-back source selector; out-of-range codes yield zero data and err_o.
module wb_src_mux
    import wb_pipe_stage_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] mem_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] data_o,
    output logic              err_o
);

    always_comb begin
        err_o  = (32'(sel_i) >= NUM_SRC);
        data_o = '0;
        if (!err_o) begin
            case (32'(sel_i))
                WB_SRC_ALU: data_o = alu_i;
                WB_SRC_MEM: data_o = mem_i;
                WB_SRC_PC:  data_o = pc_i;
                WB_SRC_IMM: data_o = imm_i;
                default:    data_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/wb_pipe_stage.sv
// Registered write-back stage: latches the retiring instruction, waits on slow loads,
// and drives the register-file write port plus forwarding/status flags.
module wb_pipe_stage
    import wb_pipe_stage_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int NUM_SRC    = 4,
    parameter int SEL_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_alu,
    input  logic [DATA_W-1:0]     in_mem,
    input  logic [DATA_W-1:0]     in_pc_inc,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_wr_en,
    input  logic [REG_ADDR_W-1:0] in_wr_addr,
    input  logic                  in_halt,
    input  logic                  mem_rdy,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  fwd_valid,
    output logic                  busy,
    output logic                  halt_out,
    output logic                  sel_err
);

    localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(WB_SRC_MEM);

    wb_state_e             state_q, state_d;
    logic                  wr_en_q, wr_en_d;
    logic                  halt_lat_q, halt_lat_d;
    logic                  done_q, done_d;
    logic                  sel_err_q, sel_err_d;
    logic                  halt_q, halt_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [REG_ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [DATA_W-1:0]     mux_data;
    logic                  mux_err;
    logic                  accept;
    logic                  retiring;
    logic                  load_new;

    wb_src_mux #(
        .DATA_W (DATA_W),
        .NUM_SRC(NUM_SRC),
        .SEL_W  (SEL_W)
    ) u_src_mux (
        .sel_i (in_sel),
        .alu_i (in_alu),
        .mem_i (in_mem),
        .pc_i  (in_pc_inc),
        .imm_i (in_imm),
        .data_o(mux_data),
        .err_o (mux_err)
    );

    assign busy     = (state_q == ST_MEM_WAIT);
    assign accept   = in_valid & ~stall & ~busy & ~flush;
    // A flush in the VALID cycle discards the latched instruction before it writes.
    assign retiring = (state_q == ST_VALID) & ~flush;
    assign wb_en     = retiring & wr_en_q & ~done_q;
    assign fwd_valid = wb_en;
    assign wb_addr   = addr_q;
    assign wb_data   = data_q;
    assign halt_out  = halt_q | (retiring & halt_lat_q);
    assign sel_err   = sel_err_q;

    always_comb begin
        state_d     = state_q;
        wr_en_d     = wr_en_q;
        halt_lat_d  = halt_lat_q;
        done_d      = done_q;
        sel_err_d   = sel_err_q;
        addr_d      = addr_q;
        pend_addr_d = pend_addr_q;
        data_d      = data_q;
        load_new    = 1'b0;
        halt_d      = halt_q | (retiring & halt_lat_q);

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: load_new = accept;
                ST_VALID: begin
                    // Held under stall, but the write has already happened once.
                    if (stall)       done_d   = 1'b1;
                    else if (accept) load_new = 1'b1;
                    else             state_d  = ST_IDLE;
                end
                ST_MEM_WAIT: begin
                    if (mem_rdy) begin
                        state_d = ST_VALID;
                        addr_d  = pend_addr_q;
                        data_d  = in_mem;
                        done_d  = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (load_new) begin
            wr_en_d    = in_wr_en & ~mux_err;
            halt_lat_d = in_halt;
            done_d     = 1'b0;
            sel_err_d  = sel_err_q | mux_err;
            if ((in_sel == SEL_MEM) && !mem_rdy && !mux_err) begin
                state_d     = ST_MEM_WAIT;
                pend_addr_d = in_wr_addr;
            end else begin
                state_d = ST_VALID;
                addr_d  = in_wr_addr;
                data_d  = mux_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_en_q     <= 1'b0;
            halt_lat_q  <= 1'b0;
            done_q      <= 1'b0;
            sel_err_q   <= 1'b0;
            halt_q      <= 1'b0;
            addr_q      <= '0;
            pend_addr_q <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            halt_lat_q  <= halt_lat_d;
            done_q      <= done_d;
            sel_err_q   <= sel_err_d;
            halt_q      <= halt_d;
            addr_q      <= addr_d;
            pend_addr_q <= pend_addr_d;
            data_q      <= data_d;
        end
    end

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Bench for wb_pipe_stage: directed vector table, a NUM_SRC=3 corner sequence, and
// randomized traffic compared against a transaction-level reference model.
module tb_wb_pipe_stage;

    localparam int NSRC = 4;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid, in_wr_en, in_halt, mem_rdy;
    logic [15:0] in_alu, in_mem, in_pc_inc, in_imm;
    logic [1:0]  in_sel;
    logic [2:0]  in_wr_addr;
    logic        wb_en, fwd_valid, busy, halt_out, sel_err;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        wb_en3, fwd_valid3, busy3, halt_out3, sel_err3;
    logic [2:0]  wb_addr3;
    logic [15:0] wb_data3;

    always #5 clk = ~clk;

    wb_pipe_stage #(.DATA_W(16), .REG_ADDR_W(3), .NUM_SRC(NSRC), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_alu(in_alu), .in_mem(in_mem), .in_pc_inc(in_pc_inc), .in_imm(in_imm),
        .in_sel(in_sel), .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_halt(in_halt),
        .mem_rdy(mem_rdy), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .fwd_valid(fwd_valid), .busy(busy), .halt_out(halt_out), .sel_err(sel_err));

    wb_pipe_stage #(.DATA_W(16), .REG_ADDR_W(3), .NUM_SRC(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_alu(in_alu), .in_mem(in_mem), .in_pc_inc(in_pc_inc), .in_imm(in_imm),
        .in_sel(in_sel), .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_halt(in_halt),
        .mem_rdy(mem_rdy), .wb_en(wb_en3), .wb_addr(wb_addr3), .wb_data(wb_data3),
        .fwd_valid(fwd_valid3), .busy(busy3), .halt_out(halt_out3), .sel_err(sel_err3));

    typedef struct {
        bit rst, vld, stall, flush, mrdy, wr, halt;
        logic [1:0]  sel;
        logic [2:0]  addr;
        logic [15:0] alu, mem, pc, imm;
        bit tm, e_en, e_busy, e_halt;
        logic [2:0]  e_addr;
        logic [15:0] e_data;
        bit tm3, e3_err, e3_halt;
    } vec_t;

    int nchecks = 0;
    int nerr    = 0;
    bit mchk    = 0;

    // Reference model: one in-flight instruction plus the visible output registers.
    bit          m_valid, m_wait, m_wr, m_written, m_hlt, m_hstick, m_estick;
    logic [2:0]  m_paddr, m_addr;
    logic [15:0] m_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_wait = 0; m_wr = 0; m_written = 0; m_hlt = 0;
        m_hstick = 0; m_estick = 0; m_paddr = 0; m_addr = 0; m_data = 0;
    endtask

    task automatic check_model();
        bit live;
        live = m_valid && !m_wait && !flush;
        chk("model_wb_en", wb_en, live && m_wr && !m_written);
        chk("model_fwd_valid", fwd_valid, live && m_wr && !m_written);
        chk("model_busy", busy, m_valid && m_wait);
        chk("model_halt_out", halt_out, m_hstick || (live && m_hlt));
        chk("model_sel_err", sel_err, m_estick);
        chk("model_wb_addr", wb_addr, m_addr);
        chk("model_wb_data", wb_data, m_data);
    endtask

    task automatic model_step();
        bit err, acc;
        logic [15:0] pick;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_valid && !m_wait && !flush && m_hlt) m_hstick = 1;
        acc = in_valid && !stall && !flush && !(m_valid && m_wait);
        if (flush) begin
            m_valid = 0;
        end else if (m_valid && m_wait) begin
            if (mem_rdy) begin
                m_wait = 0; m_written = 0; m_addr = m_paddr; m_data = in_mem;
            end
        end else if (m_valid && stall) begin
            m_written = 1;
        end else if (acc) begin
            err = (int'(in_sel) >= NSRC);
            m_estick = m_estick | err;
            m_valid = 1; m_written = 0; m_wr = in_wr_en && !err; m_hlt = in_halt;
            pick = (in_sel == 0) ? in_alu : (in_sel == 1) ? in_mem :
                   (in_sel == 2) ? in_pc_inc : in_imm;
            if (in_sel == 1 && !mem_rdy && !err) begin
                m_wait = 1; m_paddr = in_wr_addr;
            end else begin
                m_wait = 0; m_addr = in_wr_addr; m_data = err ? 16'h0 : pick;
            end
        end else begin
            m_valid = 0;
        end
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; in_valid = v.vld; stall = v.stall; flush = v.flush; mem_rdy = v.mrdy;
        in_wr_en = v.wr; in_halt = v.halt; in_sel = v.sel; in_wr_addr = v.addr;
        in_alu = v.alu; in_mem = v.mem; in_pc_inc = v.pc; in_imm = v.imm;
        @(negedge clk);
        if (mchk) check_model();
        if (v.tm) begin
            chk("tab_wb_en", wb_en, v.e_en);
            chk("tab_busy", busy, v.e_busy);
            chk("tab_halt_out", halt_out, v.e_halt);
            chk("tab_sel_err", sel_err, 0);
            chk("tab_wb_addr", wb_addr, v.e_addr);
            chk("tab_wb_data", wb_data, v.e_data);
        end
        if (v.tm3) begin
            chk("n3_wb_en", wb_en3, 0);
            chk("n3_wb_data", wb_data3, 0);
            chk("n3_sel_err", sel_err3, v.e3_err);
            chk("n3_halt_out", halt_out3, v.e3_halt);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic vec_t mk(bit r, bit vld, bit stl, bit fl, bit mr, bit wr, bit hl,
                                logic [1:0] sel, logic [2:0] addr, logic [15:0] d,
                                logic [15:0] mem, bit tm, bit e_en, bit e_busy, bit e_halt,
                                logic [2:0] e_addr, logic [15:0] e_data);
        vec_t v;
        v.rst = r; v.vld = vld; v.stall = stl; v.flush = fl; v.mrdy = mr; v.wr = wr;
        v.halt = hl; v.sel = sel; v.addr = addr; v.mem = mem;
        v.alu = (sel == 0) ? d : 16'hA0A0;
        v.pc  = (sel == 2) ? d : 16'hC0C0;
        v.imm = (sel == 3) ? d : 16'hD0D0;
        v.tm = tm; v.e_en = e_en; v.e_busy = e_busy; v.e_halt = e_halt;
        v.e_addr = e_addr; v.e_data = e_data;
        v.tm3 = 0; v.e3_err = 0; v.e3_halt = 0;
        return v;
    endfunction

    function automatic vec_t mk3(bit r, bit vld, bit hl, logic [1:0] sel, logic [15:0] d,
                                 bit e_err, bit e_halt);
        vec_t v;
        v = mk(r, vld, 0, 0, 0, 1, hl, sel, 3'd5, d, 16'h0, 0, 0, 0, 0, 3'd0, 16'h0);
        v.tm3 = 1; v.e3_err = e_err; v.e3_halt = e_halt;
        return v;
    endfunction

    vec_t tab[$];

    initial begin
        model_reset();
        // rst, vld, stall, flush, mrdy, wr, halt, sel, addr, data, mem | tm, en, busy, halt, addr, data
        tab.push_back(mk(1,0,0,0,0,0,0, 2'd0, 3'd0, 16'h0000, 16'h0000, 1, 0,0,0, 3'd0, 16'h0000));
        tab.push_back(mk(0,1,0,0,0,1,0, 2'd0, 3'd5, 16'h1234, 16'h0000, 1, 0,0,0, 3'd0, 16'h0000));
        tab.push_back(mk(0,0,0,0,0,0,0, 2'd0, 3'd0, 16'h0000, 16'h0000, 1, 1,0,0, 3'd5, 16'h1234));
        tab.push_back(mk(0,0,0,0,0,0,0, 2'd0, 3'd0, 16'h0000, 16'h0000, 1, 0,0,0, 3'd5, 16'h1234));
        // Slow load: three cycles without mem_rdy.
        tab.push_back(mk(0,1,0,0,0,1,0, 2'd1, 3'd2, 16'h0000, 16'h1111, 1, 0,0,0, 3'd5, 16'h1234));
        tab.push_back(mk(0,0,0,0,0,0,0, 2'd0, 3'd0, 16'h0000, 16'h2222, 1, 0,1,0, 3'd5, 16'h1234));
        tab.push_back(mk(0,0,0,0,0,0,0, 2'd0, 3'd0, 16'h0000, 16'h3333, 1, 0,1,0, 3'd5, 16'h1234));
        tab.push_back(mk(0,0,0,0,1,0,0, 2'd0, 3'd0, 16'h0000, 16'hBEEF, 1, 0,1,0, 3'd5, 16'h1234));
        tab.push_back(mk(0,0,0,0,0,0,0, 2'd0, 3'd0, 16'h0000, 16'h4444, 1, 1,0,0, 3'd2, 16'hBEEF));
        tab.push_back(mk(0,0,0,0,0,0,0, 2'd0, 3'd0, 16'h0000, 16'h0000, 1, 0,0,0, 3'd2, 16'hBEEF));
        // Back-to-back IMM then PC_INC.
        tab.push_back(mk(0,1,0,0,0,1,0, 2'd3, 3'd1, 16'h00FF, 16'h0000, 1, 0,0,0, 3'd2, 16'hBEEF));
        tab.push_back(mk(0,1,0,0,0,1,0, 2'd2, 3'd7, 16'h0042, 16'h0000, 1, 1,0,0, 3'd1, 16'h00FF));
        tab.push_back(mk(0,0,0,0,0,0,0, 2'd0, 3'd0, 16'h0000, 16'h0000, 1, 1,0,0, 3'd7, 16'h0042));
        tab.push_back(mk(0,0,0,0,0,0,0, 2'd0, 3'd0, 16'h0000, 16'h0000, 1, 0,0,0, 3'd7, 16'h0042));
        // Flush abandons a pending load.
        tab.push_back(mk(0,1,0,0,0,1,0, 2'd1, 3'd4, 16'h0000, 16'h5555, 1, 0,0,0, 3'd7, 16'h0042));
        tab.push_back(mk(0,1,0,1,0,1,0, 2'd0, 3'd6, 16'h9999, 16'h5555, 1, 0,1,0, 3'd7, 16'h0042));
        tab.push_back(mk(0,0,0,0,1,0,0, 2'd0, 3'd0, 16'h0000, 16'hDEAD, 1, 0,0,0, 3'd7, 16'h0042));
        tab.push_back(mk(0,0,0,0,1,0,0, 2'd0, 3'd0, 16'h0000, 16'hDEAD, 1, 0,0,0, 3'd7, 16'h0042));
        // Stall held over a VALID ALU write.
        tab.push_back(mk(0,1,0,0,0,1,0, 2'd0, 3'd3, 16'h5A5A, 16'h0000, 1, 0,0,0, 3'd7, 16'h0042));
        tab.push_back(mk(0,1,1,0,0,1,0, 2'd0, 3'd6, 16'h1111, 16'h0000, 1, 1,0,0, 3'd3, 16'h5A5A));
        tab.push_back(mk(0,1,1,0,0,1,0, 2'd0, 3'd6, 16'h1111, 16'h0000, 1, 0,0,0, 3'd3, 16'h5A5A));
        tab.push_back(mk(0,1,1,0,0,1,0, 2'd0, 3'd6, 16'h1111, 16'h0000, 1, 0,0,0, 3'd3, 16'h5A5A));
        tab.push_back(mk(0,1,0,0,0,1,0, 2'd0, 3'd6, 16'h1111, 16'h0000, 1, 0,0,0, 3'd3, 16'h5A5A));
        tab.push_back(mk(0,0,0,0,0,0,0, 2'd0, 3'd0, 16'h0000, 16'h0000, 1, 1,0,0, 3'd6, 16'h1111));
        tab.push_back(mk(0,0,0,0,0,0,0, 2'd0, 3'd0, 16'h0000, 16'h0000, 1, 0,0,0, 3'd6, 16'h1111));
        // HALT that also writes; sticky until reset.
        tab.push_back(mk(0,1,0,0,0,1,1, 2'd0, 3'd0, 16'h7777, 16'h0000, 1, 0,0,0, 3'd6, 16'h1111));
        tab.push_back(mk(0,0,0,0,0,0,0, 2'd0, 3'd0, 16'h0000, 16'h0000, 1, 1,0,1, 3'd0, 16'h7777));
        tab.push_back(mk(0,0,0,0,0,0,0, 2'd0, 3'd0, 16'h0000, 16'h0000, 1, 0,0,1, 3'd0, 16'h7777));
        tab.push_back(mk(1,0,0,0,0,0,0, 2'd0, 3'd0, 16'h0000, 16'h0000, 1, 0,0,1, 3'd0, 16'h7777));
        tab.push_back(mk(0,0,0,0,0,0,0, 2'd0, 3'd0, 16'h0000, 16'h0000, 1, 0,0,0, 3'd0, 16'h0000));

        apply(mk(1,0,0,0,0,0,0, 2'd0, 3'd0, 16'h0, 16'h0, 0, 0,0,0, 3'd0, 16'h0));
        mchk = 1;
        apply(mk(1,0,0,0,0,0,0, 2'd0, 3'd0, 16'h0, 16'h0, 0, 0,0,0, 3'd0, 16'h0));
        for (int i = 0; i < tab.size(); i++) apply(tab[i]);

        // HALT with an out-of-range select on the NUM_SRC=3 instance.
        apply(mk3(1, 0, 0, 2'd0, 16'h0000, 0, 0));
        apply(mk3(0, 1, 1, 2'd3, 16'hABCD, 0, 0));
        apply(mk3(0, 0, 0, 2'd0, 16'h0000, 1, 1));
        apply(mk3(0, 0, 0, 2'd0, 16'h0000, 1, 1));
        apply(mk3(1, 0, 0, 2'd0, 16'h0000, 1, 1));
        apply(mk3(0, 0, 0, 2'd0, 16'h0000, 0, 0));

        for (int i = 0; i < 600; i++) begin
            vec_t v;
            v = mk(0,0,0,0,0,0,0, 2'd0, 3'd0, 16'h0, 16'h0, 0, 0,0,0, 3'd0, 16'h0);
            v.rst   = ($urandom_range(0, 99) == 0);
            v.vld   = ($urandom_range(0, 3) != 0);
            v.stall = ($urandom_range(0, 3) == 0);
            v.flush = ($urandom_range(0, 15) == 0);
            v.mrdy  = $urandom_range(0, 1);
            v.wr    = ($urandom_range(0, 7) != 0);
            v.halt  = ($urandom_range(0, 31) == 0);
            v.sel   = 2'($urandom_range(0, 3));
            v.addr  = 3'($urandom_range(0, 7));
            v.alu   = 16'($urandom);
            v.mem   = 16'($urandom);
            v.pc    = 16'($urandom);
            v.imm   = 16'($urandom);
            apply(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/wb_pipe_stage.md
Name: wb_pipe_stage

Overview:
Registered write-back stage for the 16-bit pipelined core. It sits between the MEM/WB boundary and the register-file write port. It latches the retiring instruction and selects the write-back value from NUM_SRC sources (ALU, memory, PC+2 link, immediate). It waits on multi-cycle memory reads with a ready handshake, back-pressures the pipeline while waiting, and exports forwarding data to the hazard unit.

Parameters:
DATA_W, 16, data width of all sources and write-back data
REG_ADDR_W, 3, register-file address width
NUM_SRC, 4, number of valid select codes (0 ALU, 1 MEM, 2 PC_INC, 3 IMM)
SEL_W, 2, select width; NUM_SRC <= 2**SEL_W

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  downstream/global stall; hold contents
flush  in  1  discard the latched instruction
in_valid  in  1  instruction present at the stage input
in_alu  in  DATA_W  ALU result
in_mem  in  DATA_W  memory read data, valid when mem_rdy=1
in_pc_inc  in  DATA_W  PC+2 link value
in_imm  in  DATA_W  immediate (load-immediate)
in_sel  in  SEL_W  write-back source select
in_wr_en  in  1  instruction writes the register file
in_wr_addr  in  REG_ADDR_W  destination register
in_halt  in  1  instruction is HALT
mem_rdy  in  1  memory read data valid this cycle
wb_en  out  1  register-file write enable (one-cycle pulse per instruction)
wb_addr  out  REG_ADDR_W  register-file write address
wb_data  out  DATA_W  register-file write data
fwd_valid  out  1  wb_data/wb_addr valid for forwarding (equals wb_en)
busy  out  1  stage waiting on memory; upstream must stall
halt_out  out  1  sticky: HALT has retired
sel_err  out  1  sticky: in_sel >= NUM_SRC was accepted

Behaviour:
- Reset (rst=1 at an edge): state IDLE; all outputs 0; the latched data register is cleared. Reset overrides flush, stall and mem_rdy.
- States: IDLE (nothing latched), VALID (instruction latched, write this cycle), MEM_WAIT (MEM-source instruction latched, data pending).
- Accept condition: in_valid & ~stall & ~busy & ~flush. An instruction accepted at edge N produces wb_en=1 during cycle N+1.
- At accept, data is chosen by in_sel and registered:
  - ALU, PC_INC and IMM sources are registered directly. Next state VALID.
  - MEM source with mem_rdy=1: in_mem is registered. Next state VALID.
  - MEM source with mem_rdy=0: next state MEM_WAIT. busy=1 combinationally from the state.
- MEM_WAIT: on each edge where mem_rdy=1, in_mem is registered and the state moves to VALID. busy stays 1 until that edge, with no time-out. stall does not block leaving MEM_WAIT.
- VALID: wb_en = latched wr_en for exactly one cycle. Next state is VALID if a new accept occurs (back-to-back, full throughput), otherwise IDLE. With stall=1, the state and outputs are held, but wb_en is forced 0 after its first cycle (no double write).
- flush: the state goes to IDLE, the latched instruction is dropped with no write, and a pending MEM_WAIT is abandoned. A flush with in_valid=1 accepts nothing.
- Out-of-range select (in_sel >= NUM_SRC): the instruction retires with wb_en=0 and wb_data=0, and sel_err is set; it clears only on rst.
- halt_out is set in the cycle the HALT instruction's VALID cycle occurs, and stays set until rst. An instruction with in_halt=1 still writes if wr_en=1.
- wb_addr and wb_data hold their last values when wb_en=0. Consumers must qualify them with wb_en/fwd_valid.
- No zero-register suppression: all addresses are writable.

Decomposition:
- A shared core package holds the select-code constants (WB_SRC_ALU=0, WB_SRC_MEM=1, WB_SRC_PC=2, WB_SRC_IMM=3) and the state encoding (IDLE, VALID, MEM_WAIT).
- One sub-module, wb_src_mux: a combinational NUM_SRC-way selector with a range-error flag, instantiated inside wb_pipe_stage.

Test Plan:
- Reset then ALU op: in_alu=16'h1234, sel=0, wr_addr=5 accepted at edge 1 -> cycle 2 has wb_en=1, wb_addr=5, wb_data=16'h1234; cycle 3 has wb_en=0.
- Multi-cycle load: sel=1, wr_addr=2, mem_rdy low for 3 cycles, then in_mem=16'hBEEF with mem_rdy=1 -> busy=1 for 3 cycles; wb_en=1 with 16'hBEEF exactly once, the cycle after mem_rdy.
- Back-to-back: IMM 16'h00FF to r1, then PC_INC 16'h0042 to r7 on consecutive cycles -> wb_en high two consecutive cycles with the matching addr/data; busy never asserted.
- Flush during MEM_WAIT with mem_rdy later high -> no wb_en pulse; state IDLE; busy drops the cycle after the flush.
- Stall held 3 cycles over a VALID ALU write -> wb_en for 1 cycle only; data is held; a new accept resumes after the stall falls.
- HALT with sel=3 (NUM_SRC=3 build), then rst -> sel_err=1, wb_en=0, halt_out=1 until rst; both are 0 after rst.
